// File: rtl/alu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dispatch_pkg
//  Description : Shared definitions for the ALU1 dispatch front end:
//                operation codes driven to the ALU lanes, the funct3
//                encodings that are decoded, and the result-FIFO entry.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_dispatch_pkg;

    // Operation codes understood by the ALU1 lanes.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;

    // Supported funct3 encodings; everything else is reported as illegal.
    localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
    localparam logic [2:0] FUNCT3_OR     = 3'b110;
    localparam logic [2:0] FUNCT3_AND    = 3'b111;

    // Tag width carried in a result entry. The top-level TAG_W parameter
    // defaults to this value and must stay equal to it.
    localparam int RES_TAG_W = 5;

    typedef struct packed {
        logic [31:0]          data;
        logic                 zero;
        logic                 illegal;
        logic [RES_TAG_W-1:0] tag;
    } res_entry_t;

    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_fifo
//  Description : In-order result FIFO with two write ports and one read
//                port. Write port 0 is stored ahead of write port 1 in the
//                same cycle. A read of an empty FIFO is ignored.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_wr_en[1:0]      per-port push enable
//                i_wr_data[1:0]    per-port entry
//                i_rd_en           pop head (ignored when empty)
//                o_rd_data         head entry
//                o_count           number of stored entries
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_fifo
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_wr_en,
    input  res_entry_t [1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output res_entry_t               o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    res_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr1;
    logic             w_rd;

    assign w_rd      = i_rd_en && (r_count != '0);
    // Port 1 lands just behind port 0 when both push; DEPTH is a power of
    // two so the pointer arithmetic wraps on its own.
    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(i_wr_en[0]);

    always_ff @(posedge clk) begin
        if (i_wr_en[0]) r_mem[r_wr_ptr]  <= i_wr_data[0];
        if (i_wr_en[1]) r_mem[w_wr_ptr1] <= i_wr_data[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_wr_en[0]) + PTR_W'(i_wr_en[1]);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_rd);
            r_count  <= r_count + CNT_W'(i_wr_en[0]) + CNT_W'(i_wr_en[1])
                        - CNT_W'(w_rd);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dispatch
//  Description : Issue-side front end for two ALU1 lanes. Accepts up to two
//                decoded requests per cycle, registers operands/operation
//                into the lanes, collects lane results into an in-order
//                FIFO and returns one result per cycle over valid/ready.
//  Ports       : req_*   request pair (slot 0 older), req_ready credit
//                alu_*   lane drive (available/operation/operands) and
//                        lane results (outp/zero_flag)
//                res_*   result stream (valid/ready/data/zero/tag/illegal)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = RES_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic                   req_ready,
    input  logic [1:0][2:0]        req_funct3,
    input  logic [1:0]             req_funct7b5,
    input  logic [1:0]             req_is_branch,
    input  logic [1:0][31:0]       req_rs1,
    input  logic [1:0][31:0]       req_rs2,
    input  logic [1:0][TAG_W-1:0]  req_tag,
    output logic [1:0]             alu_available,
    output logic [1:0][3:0]        alu_operation,
    output logic [1:0][31:0]       alu_inp1,
    output logic [1:0][31:0]       alu_inp2,
    input  logic [1:0][31:0]       alu_outp,
    input  logic [1:0]             alu_zero_flag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic                   res_zero,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_illegal
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CRD_W = CNT_W + 2;

    function automatic dec_t decode(input logic [2:0] f3, input logic f7b5,
                                    input logic is_branch);
        dec_t d;
        d.op      = OP_NOP;
        d.illegal = 1'b0;
        if (is_branch) begin
            d.op = OP_SUB;
        end else begin
            case (f3)
                FUNCT3_ADDSUB: d.op = f7b5 ? OP_SUB : OP_ADD;
                FUNCT3_AND:    d.op = OP_AND;
                FUNCT3_OR:     d.op = OP_OR;
                default:       d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    logic [1:0]             r_lane_vld;
    logic [1:0][3:0]        r_lane_op;
    logic [1:0]             r_lane_ill;
    logic [1:0][31:0]       r_lane_rs1;
    logic [1:0][31:0]       r_lane_rs2;
    logic [1:0][TAG_W-1:0]  r_lane_tag;

    dec_t [1:0]             w_dec;
    res_entry_t [1:0]       w_push;
    res_entry_t             w_head;
    logic [CNT_W-1:0]       w_count;
    logic [CRD_W-1:0]       w_need;
    logic                   w_accept;
    logic                   w_pop;

    // Two entries of headroom are reserved even for a single request so the
    // FIFO can never overflow, whatever the consumer does.
    assign w_need    = CRD_W'(w_count) + CRD_W'(r_lane_vld[0])
                     + CRD_W'(r_lane_vld[1]) + CRD_W'(2);
    assign req_ready = !rst && (w_need <= CRD_W'(DEPTH));
    // A lone slot-1 request is a protocol error and is never accepted.
    assign w_accept  = req_valid[0] && req_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        assign w_dec[gi]         = decode(req_funct3[gi], req_funct7b5[gi],
                                          req_is_branch[gi]);
        assign alu_available[gi] = r_lane_vld[gi] && !rst;
        assign alu_operation[gi] = alu_available[gi] ? r_lane_op[gi] : OP_NOP;
        assign alu_inp1[gi]      = r_lane_rs1[gi];
        assign alu_inp2[gi]      = r_lane_rs2[gi];
    end

    // Lanes hold a request for exactly one cycle, then it moves to the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_vld <= 2'b00;
        end else begin
            r_lane_vld <= w_accept ? {req_valid[1], 1'b1} : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 2; i++) begin
                r_lane_op[i]  <= w_dec[i].op;
                r_lane_ill[i] <= w_dec[i].illegal;
                r_lane_rs1[i] <= req_rs1[i];
                r_lane_rs2[i] <= req_rs2[i];
                r_lane_tag[i] <= req_tag[i];
            end
        end
    end

    // Illegal requests report zero data; the zero flag is only meaningful
    // for a subtract, where it signals equal operands.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_push[i]         = '0;
            w_push[i].illegal = r_lane_ill[i];
            w_push[i].tag     = r_lane_tag[i];
            if (!r_lane_ill[i]) begin
                w_push[i].data = alu_outp[i];
                w_push[i].zero = (r_lane_op[i] == OP_SUB) && alu_zero_flag[i];
            end
        end
    end

    assign res_valid = !rst && (w_count != '0);
    assign w_pop     = res_valid && res_ready;

    alu_result_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_lane_vld),
        .i_wr_data (w_push),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_count)
    );

    assign res_data    = w_head.data;
    assign res_zero    = w_head.zero;
    assign res_illegal = w_head.illegal;
    assign res_tag     = w_head.tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_dispatch
//  Description : Self-checking bench for alu_dispatch. Provides an ALU1
//                model on the lane interface, a directed vector table,
//                hand-written multi-cycle sequences and a randomized phase
//                checked against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_dispatch;
    import alu_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic                  req_ready;
    logic [1:0][2:0]       req_funct3;
    logic [1:0]            req_funct7b5;
    logic [1:0]            req_is_branch;
    logic [1:0][31:0]      req_rs1;
    logic [1:0][31:0]      req_rs2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [1:0]            alu_available;
    logic [1:0][3:0]       alu_operation;
    logic [1:0][31:0]      alu_inp1;
    logic [1:0][31:0]      alu_inp2;
    logic [1:0][31:0]      alu_outp;
    logic [1:0]            alu_zero_flag;
    logic                  res_valid;
    logic                  res_ready;
    logic [31:0]           res_data;
    logic                  res_zero;
    logic [TAG_W-1:0]      res_tag;
    logic                  res_illegal;

    alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_is_branch(req_is_branch), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_tag(req_tag),
        .alu_available(alu_available), .alu_operation(alu_operation),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
        .alu_outp(alu_outp), .alu_zero_flag(alu_zero_flag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_tag(res_tag), .res_illegal(res_illegal)
    );

    always #5 clk = ~clk;

    // ALU1 model: garbage for NOP so un-zeroed illegal data is visible.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            case (alu_operation[i])
                OP_ADD:  alu_outp[i] = alu_inp1[i] + alu_inp2[i];
                OP_SUB:  alu_outp[i] = alu_inp1[i] - alu_inp2[i];
                OP_AND:  alu_outp[i] = alu_inp1[i] & alu_inp2[i];
                OP_OR:   alu_outp[i] = alu_inp1[i] | alu_inp2[i];
                default: alu_outp[i] = 32'hDEADBEEF;
            endcase
            alu_zero_flag[i] = (alu_outp[i] == 32'd0);
        end
    end

    typedef struct packed {
        logic [31:0]      data;
        logic             zero;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic        f7;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        ill;
        logic [3:0]  op;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    exp_t q[$];
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic f7,
                                   input logic br, input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        e.data = 32'd0; e.zero = 1'b0; e.ill = 1'b0; e.tag = tag;
        if (br || (f3 == 3'b000 && f7)) begin
            e.data = a - b;
            e.zero = (a == b);
        end else if (f3 == 3'b000) e.data = a + b;
        else if (f3 == 3'b111)     e.data = a & b;
        else if (f3 == 3'b110)     e.data = a | b;
        else                       e.ill  = 1'b1;
        return e;
    endfunction

    task automatic set_slot(input int s, input logic [2:0] f3, input logic f7,
                            input logic br, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_funct3[s] = f3; req_funct7b5[s] = f7; req_is_branch[s] = br;
        req_rs1[s] = a; req_rs2[s] = b; req_tag[s] = tag;
    endtask

    task automatic rand_slot(input int s);
        logic [2:0] f3;
        int sel;
        sel = $urandom_range(0, 5);
        f3  = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b110 : (sel == 2) ? 3'b111 :
              (sel == 3) ? 3'b000 : 3'($urandom);
        set_slot(s, f3, 1'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0) ? 32'd77 : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'd77 : $urandom,
                 TAG_W'($urandom));
    endtask

    // One clock with the reference model: called at a negedge after inputs
    // are driven; leaves at the following negedge.
    task automatic cycle();
        exp_t e;
        #1;
        chk("credit", req_ready, (q.size() + 2 <= DEPTH));
        if (res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("result", {res_data, res_zero, res_illegal, res_tag}, e);
            end
        end
        if (req_valid[0] && req_ready) begin
            n_acc++;
            q.push_back(model(req_funct3[0], req_funct7b5[0], req_is_branch[0],
                              req_rs1[0], req_rs2[0], req_tag[0]));
            if (req_valid[1])
                q.push_back(model(req_funct3[1], req_funct7b5[1], req_is_branch[1],
                                  req_rs1[1], req_rs2[1], req_tag[1]));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        req_valid = 2'b00;
        res_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_empty", q.size(), 0);
        cycle();
        chk("drain_res_valid", res_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, OP_ADD};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 32'd10,       32'd3,        32'd7,        1'b0, 1'b0, OP_SUB};
        tbl[2]  = '{3'b000, 1'b0, 1'b1, 32'hDEAD,     32'hDEAD,     32'd0,        1'b1, 1'b0, OP_SUB};
        tbl[3]  = '{3'b000, 1'b0, 1'b1, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, OP_SUB};
        tbl[4]  = '{3'b111, 1'b0, 1'b0, 32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b0, OP_AND};
        tbl[5]  = '{3'b110, 1'b0, 1'b0, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, OP_OR};
        tbl[6]  = '{3'b001, 1'b0, 1'b0, 32'd3,        32'd3,        32'd0,        1'b0, 1'b1, OP_NOP};
        tbl[7]  = '{3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, OP_ADD};
        tbl[8]  = '{3'b000, 1'b1, 1'b0, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, OP_SUB};
        tbl[9]  = '{3'b100, 1'b0, 1'b0, 32'd6,        32'd5,        32'd0,        1'b0, 1'b1, OP_NOP};
        tbl[10] = '{3'b110, 1'b0, 1'b1, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, OP_SUB};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, OP_SUB};

        rst = 1'b1; res_ready = 1'b0; req_valid = 2'b00;
        set_slot(0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, '0);
        set_slot(1, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_available", alu_available, 0);
        chk("rst_operation", alu_operation, {OP_NOP, OP_NOP});
        rst = 1'b0;

        // Directed table: one request at a time, exact latency checked.
        for (int k = 0; k < 12; k++) begin
            set_slot(0, tbl[k].f3, tbl[k].f7, tbl[k].br, tbl[k].a, tbl[k].b, TAG_W'(k));
            req_valid = 2'b01;
            res_ready = 1'b0;
            #1;
            chk("tbl_ready", req_ready, 1);
            @(posedge clk); @(negedge clk);
            req_valid = 2'b00;
            chk("tbl_available", alu_available, 2'b01);
            chk("tbl_operation", alu_operation[0], tbl[k].op);
            chk("tbl_early_valid", res_valid, 0);
            @(posedge clk); @(negedge clk);
            chk("tbl_valid", res_valid, 1);
            chk("tbl_result", {res_data, res_zero, res_illegal, res_tag},
                {tbl[k].d, tbl[k].z, tbl[k].ill, TAG_W'(k)});
            res_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            res_ready = 1'b0;
            chk("tbl_popped", res_valid, 0);
        end

        // Dual issue: sub then and, returned in slot order.
        set_slot(0, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 5'd1);
        set_slot(1, 3'b111, 1'b0, 1'b0, 32'hFF, 32'h0F, 5'd2);
        req_valid = 2'b11;
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        chk("t2_available", alu_available, 2'b11);
        chk("t2_operation", alu_operation, {OP_AND, OP_SUB});
        @(posedge clk); @(negedge clk);
        chk("t2_first", {res_valid, res_data, res_tag}, {1'b1, 32'd7, 5'd1});
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t2_second", {res_valid, res_data, res_tag}, {1'b1, 32'h0F, 5'd2});
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        chk("t2_empty", res_valid, 0);

        // Backpressure: only two pairs fit, then credit is withheld.
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            rand_slot(0); rand_slot(1);
            req_valid = 2'b11;
            cycle();
        end
        chk("t4_accepts", n_acc, 2);
        chk("t4_held_valid", res_valid, 1);
        drain();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 9);
            req_valid = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            rand_slot(0); rand_slot(1);
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Reset with three buffered results discards them.
        res_ready = 1'b0;
        rand_slot(0); rand_slot(1); req_valid = 2'b11; cycle();
        rand_slot(0); req_valid = 2'b01; cycle();
        req_valid = 2'b00; cycle();
        chk("t6_buffered", res_valid, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t6_rst_valid", res_valid, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_available", alu_available, 0);
        rst = 1'b0;
        q.delete();
        #1;
        chk("t6_post_ready", req_ready, 1);
        chk("t6_post_valid", res_valid, 0);
        set_slot(0, 3'b000, 1'b0, 1'b0, 32'd20, 32'd22, 5'd3);
        req_valid = 2'b01;
        cycle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
